// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption engine. One full cipher round (SubBytes,
// ShiftRows, MixColumns, AddRoundKey) per clock. Round keys are read from an
// external key-schedule store through the rk_idx/rk_data port.
module aes128_enc_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pt_valid,
  output logic         pt_ready,
  input  logic [127:0] pt_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic [127:0] ct_data
);

  if (NR != 10) begin : gNrCheck
    $fatal(1, "aes128_enc_iter: only NR = 10 is supported");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  // Forward S-box, indexed by input byte.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; row 0 sits in the most significant byte.
  function automatic logic [31:0] mixColumn(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  logic [1:0]   fsmState;
  logic [3:0]   roundCnt;
  logic [127:0] stateReg;
  logic [127:0] subShifted;
  logic [127:0] mixed;

  // Round datapath: SubBytes fused with ShiftRows (out[r][c] = in[r][(c+r)%4]),
  // then MixColumns on the shifted state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    subShifted = '0;
    mixed      = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        subShifted[127 - 8*(4*c + r) -: 8] = SBOX[stateReg[127 - 8*(4*((c + r) % 4) + r) -: 8]];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mixed[127 - 32*c -: 32] = mixColumn(subShifted[127 - 32*c -: 32]);
    end
  end

  // Handshake outputs decode from state only; pt_ready is held low while reset is asserted.
  assign pt_ready = rst_n && (fsmState == IDLE);
  assign rk_idx   = (fsmState == RUN) ? roundCnt : 4'd0;

  // Control FSM and state/ciphertext registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsmState <= IDLE;
      roundCnt <= 4'd0;
      stateReg <= '0;
      ct_valid <= 1'b0;
      ct_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
      case (fsmState)
        IDLE: begin
          if (pt_valid) begin
            stateReg <= pt_data ^ rk_data;
            roundCnt <= 4'd1;
            fsmState <= RUN;
          end
        end
        RUN: begin
          if (roundCnt == LAST_ROUND) begin
            ct_data  <= subShifted ^ rk_data;
            ct_valid <= 1'b1;
            fsmState <= HOLD;
          end else begin
            stateReg <= mixed ^ rk_data;
            roundCnt <= roundCnt + 4'd1;
          end
        end
        HOLD: begin
          if (ct_ready) begin
            ct_valid <= 1'b0;
            roundCnt <= 4'd0;
            fsmState <= IDLE;
          end
        end
        default: begin
          roundCnt <= 4'd0;
          fsmState <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Self-checking bench for aes128_enc_iter: FIPS vector table, multi-cycle
// handshake/reset sequences, and a random run against an independent
// AES-128 reference model through a scoreboard queue.
module tb_aes128_enc_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pt_valid;
  logic         pt_ready;
  logic [127:0] pt_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         ct_valid;
  logic         ct_ready;
  logic [127:0] ct_data;

  aes128_enc_iter #(.NR(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .pt_data  (pt_data),
    .rk_idx   (rk_idx),
    .rk_data  (rk_data),
    .ct_valid (ct_valid),
    .ct_ready (ct_ready),
    .ct_data  (ct_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  int           inCount  = 0;
  int           outCount = 0;
  logic [7:0]   sboxT [256];
  logic [127:0] rkStore [16];
  logic [127:0] curKey;
  logic [127:0] sbQ [$];
  vec_t         vecs [3];

  // Key-schedule store: combinational lookup by requested index.
  assign rk_data = rkStore[rk_idx];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box derived from first principles: multiplicative inverse then affine map.
  task automatic buildSbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sboxT[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] keyRound(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sboxT[t[31:24]], sboxT[t[23:16]], sboxT[t[15:8]], sboxT[t[7:0]]} ^ {rcon, 24'h000000};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aesModel(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk;
    logic [127:0] res;
    rk = keyRound(key, 0);
    for (int j = 0; j < 16; j++) s[j] = pt[127 - 8*j -: 8] ^ rk[127 - 8*j -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      rk = keyRound(key, rnd);
      for (int j = 0; j < 16; j++) t[j] = sboxT[s[j]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r + 4*c] = t[r + 4*((c + r) % 4)];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ rk[127 - 8*j -: 8];
    end
    res = '0;
    for (int j = 0; j < 16; j++) res[127 - 8*j -: 8] = s[j];
    return res;
  endfunction

  task automatic loadKey(input logic [127:0] key);
    curKey = key;
    for (int r = 0; r < 16; r++) begin
      if (r <= 10) rkStore[r] = keyRound(key, r);
      else         rkStore[r] = '0;
    end
  endtask

  // Scoreboard: push expected ciphertext on acceptance, pop on output handshake.
  always @(negedge clk) begin
    if (rst_n && pt_valid && pt_ready) begin
      sbQ.push_back(aesModel(curKey, pt_data));
      inCount++;
    end
    if (rst_n && ct_valid && ct_ready) begin
      outCount++;
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra_output: got ct %h expected no output", ct_data);
      end else begin
        check("sb_ct", ct_data, sbQ.pop_front());
      end
    end
  end

  // Call at a negedge; returns at a negedge with ct_valid high unless the bound expired.
  task automatic waitCtValid(input int maxCyc, input string name);
    int n;
    n = 0;
    while (ct_valid !== 1'b1 && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(ct_valid), 128'(1'b1));
  endtask

  task automatic drainOne();
    @(posedge clk); #1 ct_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 ct_ready = 1'b0;
    @(negedge clk);
  endtask

  // One block with per-cycle rk_idx/latency checks against a table entry.
  task automatic runOne(input vec_t v, input int id);
    @(posedge clk); #1;
    loadKey(v.key);
    pt_data  = v.pt;
    pt_valid = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d_pt_ready_idle", id), 128'(pt_ready), 128'(1'b1));
    check($sformatf("v%0d_rk_idx0", id), 128'(rk_idx), 128'(0));
    check($sformatf("v%0d_model_vs_table", id), aesModel(v.key, v.pt), v.ct);
    @(posedge clk); #1;
    pt_valid = 1'b0;
    pt_data  = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("v%0d_rk_idx%0d", id, k), 128'(rk_idx), 128'(k));
      check($sformatf("v%0d_no_early_valid%0d", id, k), 128'(ct_valid), 128'(1'b0));
      check($sformatf("v%0d_pt_ready_busy%0d", id, k), 128'(pt_ready), 128'(1'b0));
      @(posedge clk);
    end
    @(negedge clk);
    check($sformatf("v%0d_ct_valid_e10", id), 128'(ct_valid), 128'(1'b1));
    check($sformatf("v%0d_ct_data", id), ct_data, v.ct);
    check($sformatf("v%0d_hold_rk_idx", id), 128'(rk_idx), 128'(0));
    drainOne();
    check($sformatf("v%0d_idle_ct_valid", id), 128'(ct_valid), 128'(1'b0));
    check($sformatf("v%0d_idle_pt_ready", id), 128'(pt_ready), 128'(1'b1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc [3];
    int nAcc;
    int startOut;
    int target;
    bit loadNext;
    bit accepted;
    bit done;
    logic [127:0] k;
    logic [127:0] p;

    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h3243f6a8885a308d313198a2e0370734,
                ct: 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f, pt: 128'h00112233445566778899aabbccddeeff,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{key: 128'h0, pt: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst_n = 1'b0; pt_valid = 1'b0; ct_ready = 1'b0; pt_data = '0;
    buildSbox();
    loadKey('0);
    repeat (3) @(negedge clk);
    check("rst_pt_ready", 128'(pt_ready), 128'(1'b0));
    check("rst_ct_valid", 128'(ct_valid), 128'(1'b0));
    check("rst_ct_data", ct_data, 128'h0);
    check("rst_rk_idx", 128'(rk_idx), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_pt_ready", 128'(pt_ready), 128'(1'b1));

    // Vector table.
    for (int i = 0; i < 3; i++) runOne(vecs[i], i);

    // Output stall: 20 cycles with ct_ready low and stray pt_valid pulses.
    @(posedge clk); #1;
    loadKey(vecs[0].key); pt_data = vecs[0].pt; pt_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 pt_valid = 1'b0;
    @(negedge clk);
    waitCtValid(20, "stall_ct_valid_seen");
    for (int i = 0; i < 20; i++) begin
      check("stall_ct_valid", 128'(ct_valid), 128'(1'b1));
      check("stall_ct_data", ct_data, vecs[0].ct);
      check("stall_pt_ready", 128'(pt_ready), 128'(1'b0));
      @(posedge clk); #1;
      pt_valid = i[0];
      pt_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    @(posedge clk); #1;
    loadKey(vecs[1].key); pt_data = vecs[1].pt; pt_valid = 1'b1; ct_ready = 1'b1;
    @(negedge clk);
    check("release_no_accept", 128'(pt_ready), 128'(1'b0));
    @(posedge clk); #1 ct_ready = 1'b0;
    @(negedge clk);
    check("release_idle_pt_ready", 128'(pt_ready), 128'(1'b1));
    check("release_ct_valid_low", 128'(ct_valid), 128'(1'b0));
    @(posedge clk); #1 pt_valid = 1'b0;
    @(negedge clk);
    check("release_next_accepted", 128'(rk_idx), 128'(1));
    waitCtValid(12, "release_ct_valid_seen");
    check("release_ct_data", ct_data, vecs[1].ct);
    drainOne();

    // Back-to-back with pt_valid and ct_ready held high.
    startOut = outCount;
    nAcc = 0;
    loadNext = 1'b0;
    @(posedge clk); #1;
    loadKey(vecs[0].key); pt_data = vecs[0].pt; pt_valid = 1'b1; ct_ready = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (pt_valid && pt_ready && nAcc < 3) begin
        acc[nAcc] = cyc;
        nAcc++;
      end
      if (ct_valid && nAcc < 3) loadNext = 1'b1;
      @(posedge clk); #1;
      if (nAcc == 3) pt_valid = 1'b0;
      if (loadNext) begin
        loadKey(vecs[nAcc].key);
        pt_data  = vecs[nAcc].pt;
        loadNext = 1'b0;
      end
      if (nAcc == 3 && outCount == startOut + 3) break;
    end
    ct_ready = 1'b0;
    check("b2b_accept_count", 128'(nAcc), 128'(3));
    check("b2b_output_count", 128'(outCount - startOut), 128'(3));
    if (nAcc == 3) begin
      check("b2b_gap01", 128'(acc[1] - acc[0]), 128'(12));
      check("b2b_gap12", 128'(acc[2] - acc[1]), 128'(12));
    end
    @(negedge clk);

    // Reset asserted during round 5.
    @(posedge clk); #1;
    loadKey(vecs[2].key); pt_data = vecs[2].pt; pt_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 pt_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("mid_rk_idx5", 128'(rk_idx), 128'(5));
    rst_n = 1'b0;
    sbQ.delete();
    inCount = outCount;
    #1;
    check("async_ct_valid", 128'(ct_valid), 128'(1'b0));
    check("async_ct_data", ct_data, 128'h0);
    check("async_pt_ready", 128'(pt_ready), 128'(1'b0));
    check("async_rk_idx", 128'(rk_idx), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_pt_ready", 128'(pt_ready), 128'(1'b1));
    check("rel_ct_valid", 128'(ct_valid), 128'(1'b0));
    runOne(vecs[0], 3);

    // Random blocks with random output stalls.
    for (int b = 0; b < 1000; b++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      loadKey(k);
      pt_data  = p;
      pt_valid = 1'b1;
      ct_ready = ($urandom_range(0, 3) != 0);
      accepted = 1'b0;
      done     = 1'b0;
      target   = outCount + 1;
      for (int n = 0; n < 200 && !done; n++) begin
        @(negedge clk);
        if (pt_valid && pt_ready) accepted = 1'b1;
        @(posedge clk); #1;
        if (accepted) pt_valid = 1'b0;
        ct_ready = ($urandom_range(0, 3) != 0);
        done = (outCount == target);
      end
      if (!done) begin
        checks++;
        failures++;
        $display("FAIL rand_timeout: block %0d got outputs=%0d expected %0d", b, outCount, target);
        break;
      end
    end
    ct_ready = 1'b0;
    pt_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("final_in_out_count", 128'(outCount), 128'(inCount));
    check("final_sb_empty", 128'(sbQ.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
